// File: rtl/sprite_update_scheduler.sv
// sprite_update_scheduler: queues CPU sprite writes and clear-all commands
// from the Avalon slave port and replays them into the sprite register file
// during vertical blanking, so the renderer never sees a half-updated frame.
module sprite_update_scheduler #(
  parameter int NUM_SPRITES = 30,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        vblank,
  output logic        spr_we,
  output logic [4:0]  spr_index,
  output logic [31:0] spr_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] ADDR_CLEAR   = 6'd60;
  localparam logic [5:0] ADDR_STATUS  = 6'd61;
  localparam logic [5:0] ADDR_OVF_CLR = 6'd62;

  localparam logic [5:0]       SPR_LIMIT  = 6'(NUM_SPRITES);
  localparam logic [4:0]       LAST_IDX   = 5'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // queue storage: entry = {clr, index[4:0], data[31:0]}
  logic [37:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  // frame tracking and control state
  logic             vblank_q;
  logic [15:0]      frame_count;
  state_t           state;
  logic [CNT_W-1:0] pending;
  logic [4:0]       clr_idx;

  // decoded bus and queue handshakes
  logic        wr_sel;
  logic        push_sprite;
  logic        push_clear;
  logic        push_req;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        rise;
  logic        busy;
  logic [37:0] push_entry;
  logic [37:0] head;
  logic        head_clr;
  logic [4:0]  head_index;
  logic [31:0] head_data;
  logic [31:0] status_word;

  // decode the bus access and the push/pop/rise conditions for this cycle
  always_comb begin
    wr_sel      = chipselect && write;
    push_sprite = wr_sel && (address < SPR_LIMIT);
    push_clear  = wr_sel && (address == ADDR_CLEAR);
    push_req    = push_sprite || push_clear;
    fifo_full   = (fifo_count == FULL_COUNT);
    push        = push_req && !fifo_full;
    pop         = (state == DRAIN) && vblank && (fifo_count != '0);
    rise        = vblank && !vblank_q;
    busy        = (state != IDLE);
    push_entry  = push_clear ? {1'b1, 5'd0, 32'd0}
                             : {1'b0, address[4:0], writedata};
    head        = mem[rd_ptr];
    head_clr    = head[37];
    head_index  = head[36:32];
    head_data   = head[31:0];
    status_word = {frame_count, busy, overflow, 8'd0, 6'(fifo_count)};
  end

  // entry storage needs no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // queue pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_sel && (address == ADDR_OVF_CLR)) begin
        overflow <= 1'b0;
      end
    end
  end

  // vblank edge detector and frame counter; vblank_q starts high so a level
  // already present at reset release is not mistaken for a new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vblank_q    <= 1'b1;
      frame_count <= 16'd0;
    end else begin
      vblank_q <= vblank;
      if (rise) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // registered read port; holds the last returned word between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata <= 32'd0;
    end else if (chipselect && read) begin
      readdata <= (address == ADDR_STATUS) ? status_word : 32'd0;
    end
  end

  // commit FSM: snapshot the queue on a frame start, drain it while vblank
  // lasts, and expand clear-all commands into one zero write per sprite
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      clr_idx   <= 5'd0;
      spr_we    <= 1'b0;
      spr_index <= 5'd0;
      spr_data  <= 32'd0;
    end else begin
      spr_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rise && (fifo_count != '0)) begin
            pending <= fifo_count;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pop) begin
            state <= IDLE;
          end else begin
            pending <= pending - CNT_ONE;
            if (head_clr) begin
              clr_idx <= 5'd0;
              state   <= CLEAR;
            end else begin
              spr_we    <= 1'b1;
              spr_index <= head_index;
              spr_data  <= head_data;
              if (pending == CNT_ONE) begin
                state <= IDLE;
              end
            end
          end
        end
        CLEAR: begin
          spr_we    <= 1'b1;
          spr_index <= clr_idx;
          spr_data  <= 32'd0;
          clr_idx   <= clr_idx + 5'd1;
          if (clr_idx == LAST_IDX) begin
            state <= (pending != '0) ? DRAIN : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// tb_sprite_update_scheduler: directed scenarios against a queue-based
// frame-commit model, plus literal expectations on observed sprite writes.
module tb_sprite_update_scheduler;

  localparam int NUM_SPRITES = 30;
  localparam int FIFO_DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [5:0]  address = 6'd0;
  logic [31:0] writedata = 32'd0;
  logic        vblank = 1'b0;
  logic [31:0] readdata;
  logic        spr_we;
  logic [4:0]  spr_index;
  logic [31:0] spr_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  sprite_update_scheduler #(
    .NUM_SPRITES(NUM_SPRITES),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .write     (write),
    .read      (read),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .vblank    (vblank),
    .spr_we    (spr_we),
    .spr_index (spr_index),
    .spr_data  (spr_data)
  );

  // free-running clock
  always #5 clk = ~clk;

  // edge counter used to time observed writes
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        clr;
    logic [4:0]  idx;
    logic [31:0] data;
  } entry_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  idx;
    logic [31:0] data;
  } slot_t;

  entry_t      m_fifo[$];
  slot_t       m_slots[$];
  int          m_commit_left;
  logic        m_vb_prev;
  logic [15:0] m_frame;
  logic        m_ovf;
  logic        m_we;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] m_rd;
  logic        m_busy_pre;
  logic        m_rise;
  int          m_size_pre;
  entry_t      m_e;
  slot_t       m_s;

  // model: queued updates are committed on a frame start; a clear expands
  // into a bubble followed by one zero write per sprite
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_slots.delete();
      m_commit_left = 0;
      m_vb_prev     = 1'b1;
      m_frame       = 16'd0;
      m_ovf         = 1'b0;
      m_we          = 1'b0;
      m_idx         = 5'd0;
      m_data        = 32'd0;
      m_rd          = 32'd0;
    end else begin
      m_busy_pre = (m_slots.size() != 0) || (m_commit_left > 0);
      m_size_pre = m_fifo.size();
      m_rise     = vblank && !m_vb_prev;
      if (chipselect && read) begin
        m_rd = (address == 6'd61) ?
               {m_frame, m_busy_pre, m_ovf, 8'd0, 6'(m_size_pre)} : 32'd0;
      end
      m_we = 1'b0;
      if (m_slots.size() != 0) begin
        m_s    = m_slots.pop_front();
        m_we   = m_s.we;
        m_idx  = m_s.idx;
        m_data = m_s.data;
      end else if (m_commit_left > 0) begin
        if (vblank && m_fifo.size() != 0) begin
          m_e = m_fifo.pop_front();
          m_commit_left--;
          if (m_e.clr) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
              m_s.we   = 1'b1;
              m_s.idx  = 5'(i);
              m_s.data = 32'd0;
              m_slots.push_back(m_s);
            end
          end else begin
            m_we   = 1'b1;
            m_idx  = m_e.idx;
            m_data = m_e.data;
          end
        end else begin
          m_commit_left = 0;
        end
      end else if (m_rise && m_size_pre > 0) begin
        m_commit_left = m_size_pre;
      end
      if (chipselect && write) begin
        if (address < 6'd30 || address == 6'd60) begin
          if (m_size_pre == FIFO_DEPTH) begin
            m_ovf = 1'b1;
          end else begin
            m_e.clr  = (address == 6'd60);
            m_e.idx  = (address == 6'd60) ? 5'd0 : address[4:0];
            m_e.data = (address == 6'd60) ? 32'd0 : writedata;
            m_fifo.push_back(m_e);
          end
        end else if (address == 6'd62) begin
          m_ovf = 1'b0;
        end
      end
      if (m_rise) m_frame = m_frame + 16'd1;
      m_vb_prev = vblank;
    end
  end

  // compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    checkOutput("spr_we", 32'(spr_we), 32'(m_we));
    checkOutput("spr_index", 32'(spr_index), 32'(m_idx));
    checkOutput("spr_data", spr_data, m_data);
    checkOutput("readdata", readdata, m_rd);
  end

  // log of observed sprite writes for the literal checks
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int          at;
  } obs_t;
  obs_t seen[$];

  always @(negedge clk) begin
    obs_t o;
    if (spr_we === 1'b1) begin
      o.idx  = spr_index;
      o.data = spr_data;
      o.at   = cyc;
      seen.push_back(o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic [5:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chipselect = cs;
    write      = wr;
    read       = rd;
    address    = addr;
    writedata  = wdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] wdata);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, wdata);
  endtask

  task automatic read_status(output logic [31:0] value);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'd61, 32'd0);
    value = readdata;
  endtask

  task automatic set_vblank(input logic v, output int at_cyc);
    @(negedge clk);
    vblank = v;
    at_cyc = cyc;
  endtask

  task automatic check_seen(input string name, input int pos,
                            input logic [4:0] idx, input logic [31:0] data);
    if (pos >= seen.size()) begin
      total++;
      bad++;
      $display("[TB] FAIL %s actual=%0d writes required=%0d writes", name, seen.size(), pos + 1);
    end else begin
      checkOutput({name, "_idx"}, 32'(seen[pos].idx), 32'(idx));
      checkOutput({name, "_data"}, seen[pos].data, data);
    end
  endtask

  task automatic check_gap(input string name, input int pa, input int pb, input int gap);
    if (pa >= seen.size() || pb >= seen.size()) begin
      total++;
      bad++;
      $display("[TB] FAIL %s actual=%0d writes required=%0d writes", name, seen.size(), pb + 1);
    end else begin
      checkOutput(name, 32'(seen[pb].at - seen[pa].at), 32'(gap));
    end
  endtask

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] st;
    int          t_raise;
    int          mark;

    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_spr_we", 32'(spr_we), 32'd0);
    checkOutput("rst_spr_index", 32'(spr_index), 32'd0);
    checkOutput("rst_spr_data", spr_data, 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    read_status(st);
    checkOutput("rst_status", st, 32'h0000_0000);

    // two sprite writes queued while vblank is low, then committed
    $display("[TB] basic commit");
    mark = seen.size();
    bus_write(6'd3, 32'hDEAD_BEEF);
    bus_write(6'd7, 32'h1234_5678);
    repeat (3) @(posedge clk);
    read_status(st);
    checkOutput("basic_queued_status", st, 32'h0000_0002);
    checkOutput("basic_no_write", 32'(seen.size() - mark), 32'd0);
    set_vblank(1'b1, t_raise);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("basic_write_count", 32'(seen.size() - mark), 32'd2);
    check_seen("basic_w0", mark, 5'd3, 32'hDEAD_BEEF);
    check_seen("basic_w1", mark + 1, 5'd7, 32'h1234_5678);
    if (seen.size() > mark) checkOutput("basic_latency", 32'(seen[mark].at - t_raise), 32'd2);
    read_status(st);
    checkOutput("basic_done_status", st, 32'h0001_0000);
    checkOutput("model_frame_1", 32'(m_frame), 32'd1);
    set_vblank(1'b0, t_raise);

    // sprite, clear-all, sprite in one frame
    $display("[TB] clear sequence");
    mark = seen.size();
    bus_write(6'd0, 32'h0000_000A);
    bus_write(6'd60, 32'hFFFF_FFFF);
    bus_write(6'd5, 32'h0000_000B);
    set_vblank(1'b1, t_raise);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("clr_write_count", 32'(seen.size() - mark), 32'd32);
    check_seen("clr_first", mark, 5'd0, 32'h0000_000A);
    for (int i = 0; i < NUM_SPRITES; i++) begin
      check_seen("clr_zero", mark + 1 + i, 5'(i), 32'd0);
    end
    check_seen("clr_last", mark + 31, 5'd5, 32'h0000_000B);
    check_gap("clr_bubble_gap", mark, mark + 1, 2);
    check_gap("clr_total_span", mark, mark + 31, 32);
    read_status(st);
    checkOutput("clr_done_status", st, 32'h0002_0000);
    checkOutput("model_frame_2", 32'(m_frame), 32'd2);
    set_vblank(1'b0, t_raise);

    // overflow: 17 pushes into a 16-deep queue
    $display("[TB] overflow");
    mark = seen.size();
    for (int i = 0; i < 17; i++) begin
      bus_write(6'(i), 32'h0000_0100 + 32'(i));
    end
    read_status(st);
    checkOutput("ovf_status", st, 32'h0002_4010);
    checkOutput("model_ovf", 32'(m_ovf), 32'd1);
    bus_write(6'd62, 32'd0);
    read_status(st);
    checkOutput("ovf_cleared_status", st, 32'h0002_0010);
    set_vblank(1'b1, t_raise);
    repeat (25) @(posedge clk);
    #1;
    checkOutput("ovf_write_count", 32'(seen.size() - mark), 32'd16);
    check_seen("ovf_first", mark, 5'd0, 32'h0000_0100);
    check_seen("ovf_last", mark + 15, 5'd15, 32'h0000_010F);
    read_status(st);
    checkOutput("ovf_done_status", st, 32'h0003_0000);
    set_vblank(1'b0, t_raise);

    // vblank ends mid-drain; leftovers and a late push go next frame
    $display("[TB] partial frame");
    mark = seen.size();
    for (int i = 0; i < 4; i++) begin
      bus_write(6'd20 + 6'(i), 32'h0000_0200 + 32'(i));
    end
    set_vblank(1'b1, t_raise);
    bus_write(6'd9, 32'h0000_0999);
    @(posedge clk);
    set_vblank(1'b0, t_raise);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("part_write_count", 32'(seen.size() - mark), 32'd2);
    check_seen("part_w0", mark, 5'd20, 32'h0000_0200);
    check_seen("part_w1", mark + 1, 5'd21, 32'h0000_0201);
    read_status(st);
    checkOutput("part_status", st, 32'h0004_0003);
    set_vblank(1'b1, t_raise);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("part_next_count", 32'(seen.size() - mark), 32'd5);
    check_seen("part_w2", mark + 2, 5'd22, 32'h0000_0202);
    check_seen("part_w3", mark + 3, 5'd23, 32'h0000_0203);
    check_seen("part_w9", mark + 4, 5'd9, 32'h0000_0999);
    read_status(st);
    checkOutput("part_done_status", st, 32'h0005_0000);
    set_vblank(1'b0, t_raise);

    // vblank high through reset release is not a frame start
    $display("[TB] vblank high at reset release");
    set_vblank(1'b1, t_raise);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    read_status(st);
    checkOutput("vbh_status_no_rise", st, 32'h0000_0000);
    set_vblank(1'b0, t_raise);
    set_vblank(1'b1, t_raise);
    repeat (2) @(posedge clk);
    read_status(st);
    checkOutput("vbh_status_rise", st, 32'h0001_0000);

    // reset in the middle of a clear-all
    $display("[TB] reset during clear");
    set_vblank(1'b0, t_raise);
    bus_write(6'd60, 32'd0);
    bus_write(6'd4, 32'h0000_0044);
    set_vblank(1'b1, t_raise);
    repeat (12) @(posedge clk);
    #2;
    checkOutput("mid_clear_we", 32'(spr_we), 32'd1);
    checkOutput("mid_clear_index", 32'(spr_index), 32'd9);
    reset = 1'b0;
    #1;
    checkOutput("abort_spr_we", 32'(spr_we), 32'd0);
    checkOutput("abort_spr_index", 32'(spr_index), 32'd0);
    checkOutput("abort_spr_data", spr_data, 32'd0);
    checkOutput("abort_readdata", readdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    mark = seen.size();
    set_vblank(1'b0, t_raise);
    set_vblank(1'b1, t_raise);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_no_writes", 32'(seen.size() - mark), 32'd0);
    read_status(st);
    checkOutput("abort_status", st, 32'h0001_0000);
    checkOutput("model_fifo_empty", 32'(m_fifo.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
